apb_master_bridge: RTL

- Sits directly downstream of the processor's peripheral request ports; turns its wr_en/rd_en requests into APB3 transfers to two peripherals.
- psel1 drives the general peripheral; psel2 drives the KMI peripheral.
- Returns read data and completion flags using a four-phase handshake.
- Adds a bounded wait-state timeout so a missing slave cannot hang the processor.

---
 rtl/apb_master_bridge.sv | 119 +++++++++++
 1 files changed

// File: rtl/apb_master_bridge.sv
// Bridges processor wr_en/rd_en request levels onto an APB3 bus with two slaves,
// returning completion through a four-phase done handshake with a wait-state timeout.
module apb_master_bridge #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [15:0] ERR_DATA = 16'hDEAD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] wr_data,
    input  logic        wr_en,
    input  logic [8:0]  wr_addr,
    output logic        wr_done,
    input  logic [8:0]  rd_addr,
    input  logic        rd_en,
    output logic [15:0] rd_data,
    output logic        rd_done,
    output logic        err,
    output logic [8:0]  paddr,
    output logic        pwrite,
    output logic [15:0] pwdata,
    output logic        psel1,
    output logic        psel2,
    output logic        penable,
    input  logic [15:0] prdata1,
    input  logic [15:0] prdata2,
    input  logic        pready1,
    input  logic        pready2
);

    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t      state, state_nx;
    logic [8:0]  addr_q;
    logic        wr_q;
    logic        sel2_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic        err_q;
    logic [15:0] wait_q;

    logic        active_ready;
    logic        timeout_hit;
    logic        done_exit;

    assign active_ready = sel2_q ? pready2 : pready1;
    assign timeout_hit  = (wait_q + 16'd1) == TIMEOUT_W;
    // The done flag is held by the request level of the transfer that is completing.
    assign done_exit    = wr_q ? !wr_en : !rd_en;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (wr_en || rd_en) state_nx = SETUP;
            SETUP:   state_nx = ACCESS;
            ACCESS:  if (active_ready || timeout_hit) state_nx = DONE;
            DONE:    if (done_exit) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            sel2_q  <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            wait_q  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (wr_en) begin
                        addr_q  <= wr_addr;
                        wr_q    <= 1'b1;
                        sel2_q  <= wr_addr[7];
                        wdata_q <= wr_data;
                        wait_q  <= '0;
                    end else if (rd_en) begin
                        addr_q  <= rd_addr;
                        wr_q    <= 1'b0;
                        sel2_q  <= rd_addr[7];
                        wait_q  <= '0;
                    end
                end
                ACCESS: begin
                    if (active_ready) begin
                        if (!wr_q) rdata_q <= sel2_q ? prdata2 : prdata1;
                        err_q <= 1'b0;
                    end else begin
                        wait_q <= wait_q + 16'd1;
                        if (timeout_hit) begin
                            err_q <= 1'b1;
                            if (!wr_q) rdata_q <= ERR_DATA;
                        end
                    end
                end
                DONE: if (done_exit) err_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign psel1   = ((state == SETUP) || (state == ACCESS)) && !sel2_q;
    assign psel2   = ((state == SETUP) || (state == ACCESS)) && sel2_q;
    assign penable = (state == ACCESS);
    assign wr_done = (state == DONE) && wr_q;
    assign rd_done = (state == DONE) && !wr_q;
    assign err     = err_q;
    assign paddr   = addr_q;
    assign pwrite  = wr_q;
    assign pwdata  = wdata_q;
    assign rd_data = rdata_q;

endmodule
